// File: rtl/out_port_pkg.sv
// Shared constants and state encoding for the CPU output-port buffer.
package out_port_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/out_port_fifo.sv
// Small circular FIFO that sits behind the output register. The head word
// is visible combinationally so the wrapper can load it on the same edge
// it pops. A push while full is accepted only if a pop happens in the
// same cycle (the slot being vacated is the one being refilled).
module out_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap modulo DEPTH; the occupancy counter tells full from empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_port_buffer.sv
// CPU output port: a registered word presented to an external device with
// a valid/ready handshake, backed by a small FIFO. When the FIFO is empty
// and the device is taking words, new writes bypass straight into the
// output register so streaming runs at one word per cycle.
module out_port_buffer
  import out_port_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       outp_wr,
  input  logic [WIDTH-1:0]           bus_in,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       cpu_stall,
  output logic [$clog2(DEPTH+2)-1:0] count,
  output logic                       overflow
);

  localparam int CW  = $clog2(DEPTH + 2);
  localparam int FCW = $clog2(DEPTH + 1);

  state_t           state;
  state_t           next_state;
  logic             transfer;
  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             fifo_push;
  logic             fifo_pop;
  logic             set_overflow;
  logic [WIDTH-1:0] fifo_head;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  out_port_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .data_in (bus_in),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = (state == PRESENT);
  assign transfer  = out_valid && out_ready;
  assign cpu_stall = fifo_full;
  assign count     = CW'(fifo_count) + CW'(out_valid);

  // State, output register and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      state <= next_state;
      if (load_en) begin
        out_data <= load_data;
      end
      if (set_overflow) begin
        overflow <= 1'b1;
      end
    end
  end

  // Decide what feeds the output register and how the FIFO moves this cycle;
  // a pop and push together when full is how a full FIFO still takes a word.
  always_comb begin
    next_state   = state;
    load_en      = 1'b0;
    load_data    = bus_in;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    set_overflow = 1'b0;
    case (state)
      IDLE: begin
        if (outp_wr) begin
          load_en    = 1'b1;
          load_data  = bus_in;
          next_state = PRESENT;
        end
      end
      PRESENT: begin
        if (transfer) begin
          if (!fifo_empty) begin
            load_en   = 1'b1;
            load_data = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = outp_wr;
          end else if (outp_wr) begin
            load_en   = 1'b1;
            load_data = bus_in;
          end else begin
            next_state = IDLE;
          end
        end else if (outp_wr) begin
          if (!fifo_full) begin
            fifo_push = 1'b1;
          end else begin
            set_overflow = 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_out_port_buffer.sv
// Directed self-checking bench for out_port_buffer with default parameters
// (WIDTH=32, DEPTH=4, so at most 5 words held including the output register).
module tb_out_port_buffer;

  logic        clock;
  logic        reset;
  logic        outp_wr;
  logic [31:0] bus_in;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        cpu_stall;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  out_port_buffer dut (
    .clock     (clock),
    .reset     (reset),
    .outp_wr   (outp_wr),
    .bus_in    (bus_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cpu_stall (cpu_stall),
    .count     (count),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; outp_wr = 1'b0; out_ready = 1'b0; bus_in = '0;
    tick();
    reset = 1'b0;
  endtask

  // Write words 1..n on consecutive cycles with the device not ready.
  task automatic fill(input int n);
    out_ready = 1'b0;
    for (int i = 1; i <= n; i++) begin
      outp_wr = 1'b1; bus_in = 32'(i);
      tick();
    end
    outp_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; outp_wr = 1'b1; bus_in = 32'hDEAD_BEEF; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0b expected 0", cpu_stall); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", out_data); end
    reset = 1'b0; outp_wr = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_single_word();
    outp_wr = 1'b1; bus_in = 32'h0000_00AA; out_ready = 1'b0;
    tick();
    outp_wr = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0b expected 1", out_valid); end
    checks++; if (out_data !== 32'hAA) begin errors++; $display("[TB] FAIL single_data: got %h expected aa", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 32'hAA) begin errors++; $display("[TB] FAIL single_idle_data: got %h expected aa", out_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL single_idle_count: got %0d expected 0", count); end
  endtask

  task automatic test_burst();
    fill(5);
    checks++; if (count !== 3'd5) begin errors++; $display("[TB] FAIL burst_count: got %0d expected 5", count); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL burst_stall: got %0b expected 1", cpu_stall); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL burst_overflow: got %0b expected 0", overflow); end
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin errors++; $display("[TB] FAIL burst_drain: got valid=%0b data=%h expected valid=1 data=%h", out_valid, out_data, 32'(i)); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL burst_idle: got valid=%0b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    fill(5);
    outp_wr = 1'b1; bus_in = 32'h66; out_ready = 1'b0;
    tick();
    outp_wr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0b expected 1", overflow); end
    checks++; if (count !== 3'd5) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 5", count); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", overflow); end
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin errors++; $display("[TB] FAIL ovf_drain: got valid=%0b data=%h expected valid=1 data=%h", out_valid, out_data, 32'(i)); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h5) begin errors++; $display("[TB] FAIL ovf_idle: got valid=%0b data=%h expected valid=0 data=5", out_valid, out_data); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky_end: got %0b expected 1", overflow); end
  endtask

  task automatic test_full_transfer_write();
    logic [31:0] expected [5];
    expected = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h77};
    apply_reset();
    fill(5);
    out_ready = 1'b1; outp_wr = 1'b1; bus_in = 32'h77;
    tick();
    outp_wr = 1'b0;
    checks++; if (count !== 3'd5) begin errors++; $display("[TB] FAIL fullxfer_count: got %0d expected 5", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fullxfer_overflow: got %0b expected 0", overflow); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== expected[i]) begin errors++; $display("[TB] FAIL fullxfer_drain: got valid=%0b data=%h expected valid=1 data=%h", out_valid, out_data, expected[i]); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fullxfer_idle: got valid=%0b expected 0", out_valid); end
  endtask

  task automatic test_bypass();
    logic [31:0] words [3];
    words = '{32'h10, 32'h20, 32'h30};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      outp_wr = 1'b1; bus_in = words[i];
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== words[i]) begin errors++; $display("[TB] FAIL bypass_data: got valid=%0b data=%h expected valid=1 data=%h", out_valid, out_data, words[i]); end
      checks++; if (count !== 3'd1 || cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL bypass_count: got count=%0d stall=%0b expected count=1 stall=0", count, cpu_stall); end
    end
    outp_wr = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 32'h30) begin errors++; $display("[TB] FAIL bypass_idle: got valid=%0b count=%0d data=%h expected valid=0 count=0 data=30", out_valid, count, out_data); end
  endtask

  task automatic test_reset_mid_burst();
    fill(3);
    checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL midrst_pre_count: got %0d expected 3", count); end
    reset = 1'b1; outp_wr = 1'b1; bus_in = 32'h99;
    tick();
    reset = 1'b0; outp_wr = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("[TB] FAIL midrst_state: got valid=%0b count=%0d expected valid=0 count=0", out_valid, count); end
    checks++; if (out_data !== 32'h0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL midrst_regs: got data=%h overflow=%0b expected data=0 overflow=0", out_data, overflow); end
    outp_wr = 1'b1; bus_in = 32'h5A;
    tick();
    outp_wr = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h5A || count !== 3'd1) begin errors++; $display("[TB] FAIL midrst_first: got valid=%0b data=%h count=%0d expected valid=1 data=5a count=1", out_valid, out_data, count); end
  endtask

  // Scenario sequence; each task leaves the inputs quiet for the next.
  initial begin
    reset = 1'b1; outp_wr = 1'b0; out_ready = 1'b0; bus_in = '0;
    test_reset();
    test_single_word();
    test_burst();
    test_overflow();
    test_full_transfer_write();
    test_bypass();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
